// File: rtl/ecc_pkg.sv
// Shared sizing and FSM encoding for the word-serial modular subtract/reduce stage.
package ecc_pkg;
  localparam int KEY_W    = 256;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = KEY_W / WORD_W;
  localparam int MAX_ITER = 4;
  localparam int IDX_W    = $clog2(NWORDS);
  localparam int ITER_W   = $clog2(MAX_ITER + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REDUCE = 2'd1;
  localparam logic [1:0] ST_FIX    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
endpackage

// File: rtl/ecc_word_sub.sv
// One word of subtract-with-borrow: {bout,diff} = a - b - bin, purely combinational.
module ecc_word_sub
  import ecc_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              bin,
  output logic [WORD_W-1:0] diff,
  output logic              bout
);
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, bin};
endmodule

// File: rtl/ecc_mod_sub_reduce.sv
// Turns |a-b| plus sign into (a-b) mod p using repeated word-serial "r - p" passes
// and an optional final "p - r" fix-up for negative differences.
module ecc_mod_sub_reduce
  import ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] mag_in,
  input  logic             neg_in,
  input  logic [KEY_W-1:0] p_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] res_out,
  output logic             err,
  output logic [1:0]       state_dbg
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds its data stable until then, ready never waits on valid.

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NWORDS - 1);
  localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);

  logic [1:0]        state;
  logic [KEY_W-1:0]  r;
  logic [KEY_W-1:0]  p;
  logic [KEY_W-1:0]  t;
  logic [KEY_W-1:0]  t_next;
  logic              neg;
  logic [IDX_W-1:0]  word_idx;
  logic [ITER_W-1:0] iter;
  logic [ITER_W-1:0] iter_inc;
  logic              borrow;
  logic              err_q;

  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] p_word;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic [WORD_W-1:0] diff;
  logic              bout;
  logic              last_word;

  assign r_word    = r[word_idx*WORD_W +: WORD_W];
  assign p_word    = p[word_idx*WORD_W +: WORD_W];
  // FIX computes p - r through the same subtractor by swapping operands.
  assign op_a      = (state == ST_FIX) ? p_word : r_word;
  assign op_b      = (state == ST_FIX) ? r_word : p_word;
  assign last_word = (word_idx == LAST_IDX);
  assign iter_inc  = iter + ITER_W'(1);

  ecc_word_sub u_word_sub (
    .a    (op_a),
    .b    (op_b),
    .bin  (borrow),
    .diff (diff),
    .bout (bout)
  );

  // Full trial difference including the word being produced this cycle.
  always_comb begin
    t_next = t;
    t_next[word_idx*WORD_W +: WORD_W] = diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      r        <= '0;
      p        <= '0;
      t        <= '0;
      neg      <= 1'b0;
      word_idx <= '0;
      iter     <= '0;
      borrow   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            r        <= mag_in;
            p        <= p_in;
            neg      <= neg_in;
            iter     <= '0;
            word_idx <= '0;
            borrow   <= 1'b0;
            if (p_in == '0) begin
              state <= ST_DONE;
              err_q <= 1'b1;
            end else begin
              state <= ST_REDUCE;
              err_q <= 1'b0;
            end
          end
        end
        ST_REDUCE: begin
          t <= t_next;
          if (!last_word) begin
            word_idx <= word_idx + IDX_W'(1);
            borrow   <= bout;
          end else begin
            word_idx <= '0;
            borrow   <= 1'b0;
            if (!bout) begin
              r    <= t_next;
              iter <= iter_inc;
              if (iter_inc == ITER_LIM) begin
                state <= ST_DONE;
                err_q <= 1'b1;
              end
            end else if (neg && (|r)) begin
              state <= ST_FIX;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_FIX: begin
          t <= t_next;
          if (!last_word) begin
            word_idx <= word_idx + IDX_W'(1);
            borrow   <= bout;
          end else begin
            word_idx <= '0;
            borrow   <= 1'b0;
            r        <= t_next;
            state    <= ST_DONE;
          end
        end
        default: begin
          if (out_ready) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign res_out   = r;
  assign err       = err_q;
  assign state_dbg = state;
endmodule
